instruction_decode_unit: RTL and testbench
==========================================

INSTRUCTION_DECODE_UNIT -- requirements
Module: instruction_decode

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 64: register, PC and immediate width.
- NUM_REGS, 32: register-file depth; index 31 is XZR.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- instruction  in  32  current instruction word, little-endian assembled.
- PC  in  64  byte address of the current instruction.
- reg_write_en  in  1  write-back enable.
- write_reg  in  5  write-back destination index.
- write_data  in  64  write-back data.
- PCSrc  out  1  1 = next PC is BranchAddress; 0 = PC+4.
- BranchAddress  out  64  branch target.
- read_data1  out  64  register operand 1.
- read_data2  out  64  register operand 2.
- sign_ext_imm  out  64  sign-extended immediate.
- ctrl  out  9  {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBranch, halt}.
- alu_op  out  2  00 add (D-type), 01 pass-B/zero-test (CB), 10 R/I-type.
- illegal  out  1  unrecognised opcode.

Function
REQ-003 Decode SHALL be purely combinational from instruction, PC and register contents, with zero-cycle latency.
REQ-004 Opcodes SHALL be recognised as follows; opcode[31:21] is authoritative:
- R-type, 11-bit: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LSL 11010011011, LSR 11010011010.
- I-type, 10-bit: ADDI 1001000100, SUBI 1101000100.
- D-type, 11-bit: LDUR 11111000010, STUR 11111000000.
- B, 6-bit: 000101.
- CBZ, 8-bit: 10110100.
- CBNZ, 8-bit: 10110101.
REQ-005 NOP (0xD503201F) SHALL drive all ctrl bits, alu_op, PCSrc and illegal to 0.
REQ-006 HALT (instruction[31:21] = 11111111111) SHALL set halt=1 and all other ctrl bits to 0, overriding the STUR/LDUR match.
REQ-007 Any other encoding SHALL set illegal=1 and all ctrl bits to 0.
REQ-008 Read ports: read_data1 = X[Rn = instr[9:5]]; read_data2 = X[Reg2Loc ? Rt = instr[4:0] : Rm = instr[20:16]].
REQ-009 Reg2Loc SHALL be 1 for STUR, CBZ and CBNZ.
REQ-010 Index 31 SHALL read as 0 regardless of writes, and writes to index 31 SHALL be discarded.
REQ-011 Immediates:
- I-type: zero-extend instr[21:10].
- D-type: sign-extend instr[20:12].
- CB: sign-extend instr[23:5].
- B: sign-extend instr[25:0].
- All other instructions: 0.
REQ-012 BranchAddress SHALL equal PC + (sign_ext_imm << 2) for B/CBZ/CBNZ and PC + 4 otherwise, computed modulo 2^64 with wrap-around ignored.
REQ-013 PCSrc SHALL be:
- B: 1.
- CBZ: (read_data2 == 0).
- CBNZ: (read_data2 != 0).
- All other instructions: 0.
REQ-014 Control per class:
- R-type: RegWrite=1, alu_op=10.
- I-type: ALUSrc=1, RegWrite=1, alu_op=10.
- LDUR: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, alu_op=00.
- STUR: Reg2Loc=1, ALUSrc=1, MemWrite=1, alu_op=00.
- CB: Reg2Loc=1, Branch=1, alu_op=01.
- B: UncondBranch=1.
REQ-015 The register file SHALL write write_data to X[write_reg] on the rising clk edge when reg_write_en=1.
REQ-016 A read of the same register in the cycle it is written SHALL return the old value until the edge, with no bypass.

Reset
REQ-017 rst_n low SHALL asynchronously clear all 32 registers to 0; writes SHALL be ignored while rst_n=0.
REQ-018 Combinational outputs SHALL keep following the decode rules during reset, reflecting the cleared registers.
REQ-019 Reset asserted mid-operation SHALL discard any pending write in that cycle.

Structure
REQ-020 Opcode constants, the ctrl bit positions and the alu_op encodings SHALL live in a shared package, cpu_pkg.
REQ-021 The register file SHALL be a single sub-module, reg_file: 2 async read ports and 1 sync write port, with XZR handling inside it.

Verification
REQ-022 Required directed scenarios:
- After reset, instruction 0xD503201F, PC=0 -> PCSrc=0, ctrl=0, illegal=0, BranchAddress=4.
- B with imm26=3 at PC=0x10 -> PCSrc=1, BranchAddress=0x1C.
- X1=0, CBZ X1 with imm19=-2 at PC=0x20 -> PCSrc=1, BranchAddress=0x18; CBNZ X1 with the same fields -> PCSrc=0.
- Write X5=0x1234, then ADD X2,X5,X31 -> read_data1=0x1234, read_data2=0; write X31=7, then read X31 -> 0.
- instruction 0xFFE00000 -> halt=1, MemWrite=0, MemRead=0; instruction 0x00000000 -> illegal=1.
- Write X3=9, then pulse rst_n low between clock edges -> X3 reads 0 immediately; a write during reset has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode constants: opcode patterns, ctrl bit positions, alu_op encodings.
package cpu_pkg;

  // 11-bit opcodes (instr[31:21])
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_HALT = 11'b11111111111;

  // 10-bit opcodes (instr[31:22])
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;

  // 8-bit opcodes (instr[31:24])
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;

  // 6-bit opcode (instr[31:26])
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [31:0] INSTR_NOP = 32'hD503201F;

  // ctrl = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBranch, halt}
  localparam int CTRL_W        = 9;
  localparam int CTRL_REG2LOC  = 8;
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_UNCOND   = 1;
  localparam int CTRL_HALT     = 0;

  localparam logic [1:0] ALU_ADD = 2'b00;  // D-type address add
  localparam logic [1:0] ALU_CB  = 2'b01;  // pass B / zero test
  localparam logic [1:0] ALU_RI  = 2'b10;  // R/I-type, funct decoded downstream

endpackage

// File: rtl/reg_file.sv
// 2R1W register file; the top index is XZR (reads 0, writes dropped).
module reg_file #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);

  localparam logic [AW-1:0] XZR = AW'(NUM_REGS - 1);

  // XZR has no storage; only the general registers are flops
  logic [DATA_W-1:0] gpr [NUM_REGS-1];

  for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_gpr
    // per-register write with async clear; reset wins over any pending write
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       gpr[g] <= '0;
      else if (we && wa == AW'(g))      gpr[g] <= wd;
    end
  end

  // asynchronous reads, no write bypass: old value until the edge
  assign rd1 = (ra1 == XZR) ? '0 : gpr[ra1];
  assign rd2 = (ra2 == XZR) ? '0 : gpr[ra2];

endmodule

// File: rtl/instruction_decode_unit.sv
// Single-cycle ARMv8-subset decode: control, immediates, operand read, branch resolve.
module instruction_decode_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] PC,
  input  logic              reg_write_en,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic              PCSrc,
  output logic [DATA_W-1:0] BranchAddress,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] sign_ext_imm,
  output logic [CTRL_W-1:0] ctrl,
  output logic [1:0]        alu_op,
  output logic              illegal
);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic        is_b, is_cbz, is_cbnz;
  logic [4:0]  rd_addr2;

  assign op11 = instruction[31:21];
  assign op10 = instruction[31:22];
  assign op8  = instruction[31:24];
  assign op6  = instruction[31:26];

  // opcode classification -> control word, alu_op and immediate
  always_comb begin
    ctrl         = '0;
    alu_op       = ALU_ADD;
    illegal      = 1'b0;
    sign_ext_imm = '0;
    is_b         = 1'b0;
    is_cbz       = 1'b0;
    is_cbnz      = 1'b0;
    if (instruction == INSTR_NOP) begin
      illegal = 1'b0;  // NOP: everything stays cleared
    end else if (op11 == OP_HALT) begin
      ctrl[CTRL_HALT] = 1'b1;
    end else if (op11 inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LSL, OP_LSR}) begin
      ctrl[CTRL_REGWRITE] = 1'b1;
      alu_op              = ALU_RI;
    end else if (op10 inside {OP_ADDI, OP_SUBI}) begin
      ctrl[CTRL_ALUSRC]   = 1'b1;
      ctrl[CTRL_REGWRITE] = 1'b1;
      alu_op              = ALU_RI;
      sign_ext_imm        = {{(DATA_W-12){1'b0}}, instruction[21:10]};
    end else if (op11 == OP_LDUR) begin
      ctrl[CTRL_ALUSRC]   = 1'b1;
      ctrl[CTRL_MEMTOREG] = 1'b1;
      ctrl[CTRL_REGWRITE] = 1'b1;
      ctrl[CTRL_MEMREAD]  = 1'b1;
      sign_ext_imm        = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
    end else if (op11 == OP_STUR) begin
      ctrl[CTRL_REG2LOC]  = 1'b1;
      ctrl[CTRL_ALUSRC]   = 1'b1;
      ctrl[CTRL_MEMWRITE] = 1'b1;
      sign_ext_imm        = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
    end else if (op8 == OP_CBZ || op8 == OP_CBNZ) begin
      ctrl[CTRL_REG2LOC]  = 1'b1;
      ctrl[CTRL_BRANCH]   = 1'b1;
      alu_op              = ALU_CB;
      is_cbz              = (op8 == OP_CBZ);
      is_cbnz             = (op8 == OP_CBNZ);
      sign_ext_imm        = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
    end else if (op6 == OP_B) begin
      ctrl[CTRL_UNCOND]   = 1'b1;
      is_b                = 1'b1;
      sign_ext_imm        = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
    end else begin
      illegal = 1'b1;
    end
  end

  // Reg2Loc selects Rt (stores, CB) instead of Rm as the second operand
  assign rd_addr2 = ctrl[CTRL_REG2LOC] ? instruction[4:0] : instruction[20:16];

  reg_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (instruction[9:5]),
    .ra2   (rd_addr2),
    .rd1   (read_data1),
    .rd2   (read_data2),
    .we    (reg_write_en),
    .wa    (write_reg),
    .wd    (write_data)
  );

  // branch resolution: target is always computed for branches, taken-ness from class and operand
  assign PCSrc = is_b | (is_cbz & (read_data2 == '0)) | (is_cbnz & (read_data2 != '0));
  assign BranchAddress = (is_b | is_cbz | is_cbnz) ? PC + (sign_ext_imm << 2)
                                                   : PC + DATA_W'(4);

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Scoreboard bench for instruction_decode_unit: directed decode vectors plus random ADD reads.
module tb_instruction_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic [63:0] PC;
  logic        reg_write_en;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic        PCSrc;
  logic [63:0] BranchAddress, read_data1, read_data2, sign_ext_imm;
  logic [8:0]  ctrl;
  logic [1:0]  alu_op;
  logic        illegal;

  always #5 clk = ~clk;

  instruction_decode_unit #(.DATA_W(64), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .PC(PC),
    .reg_write_en(reg_write_en), .write_reg(write_reg), .write_data(write_data),
    .PCSrc(PCSrc), .BranchAddress(BranchAddress), .read_data1(read_data1),
    .read_data2(read_data2), .sign_ext_imm(sign_ext_imm), .ctrl(ctrl),
    .alu_op(alu_op), .illegal(illegal)
  );

  typedef struct packed {
    logic        pcsrc;
    logic [63:0] baddr;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [8:0]  ctrl;
    logic [1:0]  alu;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mreg [32];
  int          nvec = 0;
  int          nerr = 0;

  // ctrl constants written out independently of the design package
  localparam logic [8:0] C_R    = 9'b000100000;
  localparam logic [8:0] C_I    = 9'b010100000;
  localparam logic [8:0] C_LDUR = 9'b011110000;
  localparam logic [8:0] C_STUR = 9'b110001000;
  localparam logic [8:0] C_CB   = 9'b100000100;
  localparam logic [8:0] C_B    = 9'b000000010;
  localparam logic [8:0] C_HALT = 9'b000000001;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] rx(input logic [4:0] i);
    return (i == 5'd31) ? 64'd0 : mreg[i];
  endfunction

  function automatic exp_t mk(input logic pcsrc, input logic [63:0] baddr,
                              input logic [63:0] imm, input logic [8:0] c,
                              input logic [1:0] alu, input logic ill,
                              input logic [31:0] ins);
    exp_t e;
    e.pcsrc = pcsrc; e.baddr = baddr; e.imm = imm; e.ctrl = c; e.alu = alu; e.ill = ill;
    e.rd1 = rx(ins[9:5]);
    e.rd2 = rx(c[8] ? ins[4:0] : ins[20:16]);
    return e;
  endfunction

  // drive now, let combinational logic settle, then pop and compare
  task automatic apply_now(input string tag, input logic [31:0] ins, input logic [63:0] pc,
                           input logic pcsrc, input logic [63:0] baddr, input logic [63:0] imm,
                           input logic [8:0] c, input logic [1:0] alu, input logic ill);
    exp_t e;
    instruction = ins;
    PC          = pc;
    sb.push_back(mk(pcsrc, baddr, imm, c, alu, ill, ins));
    #1;
    e = sb.pop_front();
    chk({tag, ".pcsrc"}, 64'(PCSrc), 64'(e.pcsrc));
    chk({tag, ".baddr"}, BranchAddress, e.baddr);
    chk({tag, ".rd1"},   read_data1, e.rd1);
    chk({tag, ".rd2"},   read_data2, e.rd2);
    chk({tag, ".imm"},   sign_ext_imm, e.imm);
    chk({tag, ".ctrl"},  64'(ctrl), 64'(e.ctrl));
    chk({tag, ".alu"},   64'(alu_op), 64'(e.alu));
    chk({tag, ".ill"},   64'(illegal), 64'(e.ill));
  endtask

  task automatic apply(input string tag, input logic [31:0] ins, input logic [63:0] pc,
                       input logic pcsrc, input logic [63:0] baddr, input logic [63:0] imm,
                       input logic [8:0] c, input logic [1:0] alu, input logic ill);
    @(negedge clk);
    apply_now(tag, ins, pc, pcsrc, baddr, imm, c, alu, ill);
  endtask

  task automatic wr(input logic [4:0] i, input logic [63:0] d);
    @(negedge clk);
    reg_write_en = 1'b1; write_reg = i; write_data = d;
    @(posedge clk);
    #1;
    reg_write_en = 1'b0;
    if (rst_n && i != 5'd31) mreg[i] = d;
  endtask

  initial begin
    logic [4:0]  rn, rm, rd, wi;
    logic [63:0] wd, pc;
    logic [31:0] ins;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    rst_n = 1'b0; instruction = '0; PC = '0;
    reg_write_en = 1'b0; write_reg = '0; write_data = '0;

    // during reset: decode still live, registers read 0
    #2;
    apply_now("rst_nop", 32'hD503201F, 64'h0, 1'b0, 64'h4, 64'h0, 9'h0, 2'b00, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    apply("nop",  32'hD503201F, 64'h0,  1'b0, 64'h4,  64'h0, 9'h0, 2'b00, 1'b0);
    apply("b3",   32'h14000003, 64'h10, 1'b1, 64'h1C, 64'h3, C_B,  2'b00, 1'b0);
    apply("bneg", 32'h17FFFFFF, 64'h100, 1'b1, 64'hFC, 64'hFFFF_FFFF_FFFF_FFFF, C_B, 2'b00, 1'b0);
    apply("cbz0",  32'hB4FFFFC1, 64'h20, 1'b1, 64'h18, 64'hFFFF_FFFF_FFFF_FFFE, C_CB, 2'b01, 1'b0);
    apply("cbnz0", 32'hB5FFFFC1, 64'h20, 1'b0, 64'h18, 64'hFFFF_FFFF_FFFF_FFFE, C_CB, 2'b01, 1'b0);

    // register file basics and XZR
    wr(5'd5, 64'h1234);
    apply("add5",   32'h8B1F00A2, 64'h40, 1'b0, 64'h44, 64'h0, C_R, 2'b10, 1'b0);
    wr(5'd31, 64'h7);
    apply("xzr",    32'h8B1F03E2, 64'h40, 1'b0, 64'h44, 64'h0, C_R, 2'b10, 1'b0);

    // CB with nonzero operand flips taken-ness
    wr(5'd1, 64'h55);
    apply("cbz1",  32'hB4FFFFC1, 64'h20, 1'b0, 64'h18, 64'hFFFF_FFFF_FFFF_FFFE, C_CB, 2'b01, 1'b0);
    apply("cbnz1", 32'hB5FFFFC1, 64'h20, 1'b1, 64'h18, 64'hFFFF_FFFF_FFFF_FFFE, C_CB, 2'b01, 1'b0);

    // I/D-type immediates and Reg2Loc on stores
    apply("addi",  32'h913FFC41, 64'h80, 1'b0, 64'h84, 64'hFFF, C_I, 2'b10, 1'b0);
    apply("subi",  32'hD1000C41, 64'h80, 1'b0, 64'h84, 64'h3,   C_I, 2'b10, 1'b0);
    apply("ldur",  32'hF85FF0A4, 64'h80, 1'b0, 64'h84, 64'hFFFF_FFFF_FFFF_FFFF, C_LDUR, 2'b00, 1'b0);
    apply("stur",  32'hF8008045, 64'h80, 1'b0, 64'h84, 64'h8, C_STUR, 2'b00, 1'b0);
    apply("lsl",   32'hD36010A2, 64'h80, 1'b0, 64'h84, 64'h0, C_R, 2'b10, 1'b0);
    apply("halt",  32'hFFE00000, 64'h80, 1'b0, 64'h84, 64'h0, C_HALT, 2'b00, 1'b0);
    apply("ill0",  32'h00000000, 64'h80, 1'b0, 64'h84, 64'h0, 9'h0, 2'b00, 1'b1);
    apply("pcwrap", 32'hD503201F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 64'h0, 9'h0, 2'b00, 1'b0);

    // no bypass: old value visible before the edge, new one after
    @(negedge clk);
    reg_write_en = 1'b1; write_reg = 5'd7; write_data = 64'hDEAD_BEEF_0000_0001;
    apply_now("nobyp_old", 32'h8B1F00E0, 64'h0, 1'b0, 64'h4, 64'h0, C_R, 2'b10, 1'b0);
    @(posedge clk); #1;
    reg_write_en = 1'b0; mreg[7] = 64'hDEAD_BEEF_0000_0001;
    apply("nobyp_new", 32'h8B1F00E0, 64'h0, 1'b0, 64'h4, 64'h0, C_R, 2'b10, 1'b0);

    // random writes and ADD operand reads
    for (int k = 0; k < 10; k++) begin
      wi = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      wr(wi, wd);
      rn = 5'($urandom_range(0, 31));
      rm = (k % 2 == 0) ? wi : 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      ins = 32'h8B000000 | (32'(rm) << 16) | (32'(rn) << 5) | 32'(rd);
      pc = {$urandom, $urandom} & ~64'h3;
      apply("rnd", ins, pc, 1'b0, pc + 64'd4, 64'h0, C_R, 2'b10, 1'b0);
    end

    // async reset mid-operation clears registers at once and blocks writes
    wr(5'd3, 64'h9);
    apply("x3set", 32'h8B1F0060, 64'h0, 1'b0, 64'h4, 64'h0, C_R, 2'b10, 1'b0);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    apply_now("x3rst", 32'h8B1F0060, 64'h0, 1'b0, 64'h4, 64'h0, C_R, 2'b10, 1'b0);
    reg_write_en = 1'b1; write_reg = 5'd3; write_data = 64'h5;
    @(posedge clk); #1;
    reg_write_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    apply("x3after", 32'h8B1F0060, 64'h0, 1'b0, 64'h4, 64'h0, C_R, 2'b10, 1'b0);
    apply("x5after", 32'h8B1F00A2, 64'h0, 1'b0, 64'h4, 64'h0, C_R, 2'b10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
